// File: rtl/cam_pkg.sv
// Shared types and sizing helpers for the CAM read/search path.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESULT  = 2'd3
  } cam_state_e;

  localparam int unsigned CAM_DATA_WIDTH = 8;
  localparam int unsigned CAM_ADDR_WIDTH = 2;

  function automatic int unsigned slot_count(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder: any-set, lowest set index and popcount of a slot vector.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH
) (
  input  logic [slot_count(ADDR_WIDTH)-1:0] q,
  output logic                              any,
  output logic [ADDR_WIDTH-1:0]             idx,
  output logic [ADDR_WIDTH:0]               count
);

  localparam int unsigned SLOTS = slot_count(ADDR_WIDTH);

  logic [SLOTS-1:0] v;
  logic             found;

  always_comb begin
    any   = |q;
    idx   = '0;
    count = '0;
    found = 1'b0;
    v     = q;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (v[0]) begin
        count = count + (ADDR_WIDTH+1)'(1);
        if (!found) begin
          idx   = ADDR_WIDTH'(i);
          found = 1'b1;
        end
      end
      v = v >> 1;
    end
  end

endmodule

// File: rtl/cam_search_ctrl.sv
// CAM read-side controller: issues a key lookup, retries on same-key update hazards,
// qualifies the match vector with occupancy and holds the encoded result on a valid/ready port.
module cam_search_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = CAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH       = CAM_ADDR_WIDTH,
  parameter bit          MATCH_ACTIVE_LOW = 1'b1,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [DATA_WIDTH-1:0]             req_key,
  output logic [DATA_WIDTH-1:0]             ram_key,
  input  logic [slot_count(ADDR_WIDTH)-1:0] ram_match,
  input  logic [slot_count(ADDR_WIDTH)-1:0] entry_valid,
  input  logic                              upd_strobe,
  input  logic [DATA_WIDTH-1:0]             upd_key,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_hit,
  output logic                              rsp_multi,
  output logic [ADDR_WIDTH-1:0]             rsp_addr,
  output logic [ADDR_WIDTH:0]               rsp_count,
  output logic                              rsp_stale,
  output logic                              busy
);

  localparam int unsigned SLOTS = slot_count(ADDR_WIDTH);
  localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cam_state_e         state;
  logic [RW-1:0]      retry_cnt;
  logic               stale_flag;
  logic [SLOTS-1:0]   q;
  logic               enc_any;
  logic [ADDR_WIDTH-1:0] enc_idx;
  logic [ADDR_WIDTH:0]   enc_cnt;
  logic               hazard;

  assign q         = (MATCH_ACTIVE_LOW ? ~ram_match : ram_match) & entry_valid;
  assign hazard    = upd_strobe && (upd_key == ram_key);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  cam_prio_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_enc (
    .q     (q),
    .any   (enc_any),
    .idx   (enc_idx),
    .count (enc_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ram_key    <= '0;
      retry_cnt  <= '0;
      stale_flag <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_multi  <= 1'b0;
      rsp_addr   <= '0;
      rsp_count  <= '0;
      rsp_stale  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_key   <= req_key;
            retry_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A same-key update in the lookup cycle means the RAM returns pre-update data.
          if (hazard && (retry_cnt < RW'(MAX_RETRY))) begin
            retry_cnt <= retry_cnt + RW'(1);
            state     <= ISSUE;
          end else begin
            if (hazard) stale_flag <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= enc_any;
          rsp_multi <= (enc_cnt >= (ADDR_WIDTH+1)'(2));
          rsp_addr  <= enc_idx;
          rsp_count <= enc_cnt;
          rsp_stale <= stale_flag;
          state     <= RESULT;
        end
        RESULT: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            stale_flag <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam_search_ctrl.md
Name: cam_search_ctrl

Overview:
- Read-side controller for the CAM storage RAM, which is indexed by key and returns a 2**ADDR_WIDTH-bit per-slot match vector.
- Accepts one search key at a time over a valid/ready handshake and drives the RAM lookup key.
- Captures the registered match vector and qualifies it with slot occupancy.
- Priority-encodes the result into hit / multi-hit / lowest matching address / match count, held on a valid/ready response port.

Parameters:
- DATA_WIDTH, 8, key width; equals the RAM DATA_WIDTH.
- ADDR_WIDTH, 2, slot-address width; the RAM has 2**ADDR_WIDTH slots.
- MATCH_ACTIVE_LOW, 1, 1 means a RAM bit of 0 marks a match (write clears the bit, erase sets it).
- MAX_RETRY, 3, maximum number of hazard-induced re-lookups per request.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  search request valid
- req_ready  out  1  controller can accept a request
- req_key  in  DATA_WIDTH  key to search
- ram_key  out  DATA_WIDTH  lookup key to the RAM port B data input (registered)
- ram_match  in  2**ADDR_WIDTH  RAM port B output; one-cycle registered latency
- entry_valid  in  2**ADDR_WIDTH  slot occupancy mask (1 = slot in use)
- upd_strobe  in  1  a write or erase is being applied to the RAM this cycle
- upd_key  in  DATA_WIDTH  key (RAM a_din) of that update
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_hit  out  1  at least one qualified match
- rsp_multi  out  1  two or more qualified matches
- rsp_addr  out  ADDR_WIDTH  lowest-index qualified match; 0 when there is no hit
- rsp_count  out  ADDR_WIDTH+1  number of qualified matches (0..2**ADDR_WIDTH)
- rsp_stale  out  1  retry budget was exhausted; the result may predate a concurrent update
- busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state = IDLE, ram_key = 0, retry_cnt = 0.
  - All rsp_* outputs = 0; req_ready = 1; busy = 0.
  - A reset mid-operation discards the in-flight request with no response.
- States: IDLE, ISSUE, CAPTURE, RESULT.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge: latch req_key into ram_key, clear retry_cnt, go to ISSUE.
- ISSUE:
  - ram_key is held stable; the RAM samples it at this cycle's closing edge.
  - Hazard: upd_strobe = 1 and upd_key == ram_key in this cycle means the RAM read returns pre-update data.
    - If retry_cnt < MAX_RETRY: stay in ISSUE and increment retry_cnt.
    - Otherwise: set stale_flag and go to CAPTURE.
  - No hazard: go to CAPTURE.
- CAPTURE:
  - ram_match is valid during this cycle.
  - Normalise: m = MATCH_ACTIVE_LOW ? ~ram_match : ram_match; q = m & entry_valid.
  - Register the encoder outputs and stale_flag into the rsp_* outputs; set rsp_valid = 1; go to RESULT.
  - An update to the same key during CAPTURE is ignored; the result reflects the snapshot sampled in ISSUE.
- RESULT:
  - rsp_valid = 1; all rsp_* fields are held stable while rsp_ready = 0.
  - On rsp_ready: rsp_valid = 0, clear stale_flag, go to IDLE.
  - Other rsp_* fields hold their last values after the handshake.
- Latency: request accept edge E0 -> rsp_valid high after E2 when there is no retry. Each retry adds 1 cycle.
- Throughput: at most one request per 4 cycles; req_ready is low outside IDLE.
- Encoding rules:
  - rsp_hit = |q; rsp_multi = (rsp_count >= 2).
  - rsp_addr = lowest set index of q.
  - rsp_count = popcount(q), computed at full ADDR_WIDTH+1 width so that all slots matching does not overflow.
- Boundaries:
  - entry_valid all 0 -> miss regardless of ram_match. This also covers the RAM reset state, where every bit is 0.
  - All slots matching -> rsp_count = 2**ADDR_WIDTH and rsp_addr = 0.
  - req_valid during RESULT is not accepted.
  - rsp_ready with no valid result is ignored.

Decomposition:
- Shared package cam_pkg holds:
  - state enum (IDLE=0, ISSUE=1, CAPTURE=2, RESULT=3);
  - default DATA_WIDTH / ADDR_WIDTH constants;
  - the slot-count function 2**ADDR_WIDTH.
- One combinational sub-module, cam_prio_enc (parameter ADDR_WIDTH): input q; outputs any, lowest index, popcount. It is reused later by the free-slot allocator.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, MATCH_ACTIVE_LOW=1):
- Single hit: entry_valid=4'b1111, key 0x3C, ram_match=4'b1011 -> rsp_hit=1, rsp_multi=0, rsp_addr=2, rsp_count=1. rsp_valid rises 2 cycles after accept; ram_key=0x3C during ISSUE.
- Multi-hit with mask: entry_valid=4'b1110, ram_match=4'b0000 -> rsp_hit=1, rsp_multi=1, rsp_addr=1, rsp_count=3.
- Miss and reset state: entry_valid=4'b0000, ram_match=4'b0000 -> rsp_hit=0, rsp_addr=0, rsp_count=0.
- Hazard: upd_strobe with upd_key=0x3C in the ISSUE cycle of key 0x3C, repeated 4 times.
  - 3 retries occur, then rsp_stale=1.
  - rsp_valid is delayed by 3 cycles.
  - A single hazard gives a 1-cycle delay with rsp_stale=0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready=0 throughout. With rsp_ready=1, the next request is accepted on the following cycle.
- Reset mid-operation: assert rst during CAPTURE -> outputs 0 immediately, no rsp_valid, and a fresh request completes normally afterwards.
